// File: rtl/regfile_pkg.sv
// Shared constants for the register file and the decode stage that feeds it:
// default geometry, ALU opcodes and instruction field positions.
package regfile_pkg;

  localparam int DEFAULT_DATA_W   = 32;
  localparam int DEFAULT_NUM_REGS = 32;

  typedef enum logic [5:0] {
    ALU_LW   = 6'd0,
    ALU_SW   = 6'd1,
    ALU_ADD  = 6'd2,
    ALU_ADDI = 6'd3,
    ALU_SUB  = 6'd4,
    ALU_AND  = 6'd5,
    ALU_OR   = 6'd6,
    ALU_XOR  = 6'd7,
    ALU_MUL  = 6'd8,
    ALU_MULI = 6'd9
  } aluOp_e;

  // Field positions inside a 32-bit instruction word
  localparam int OPC_LSB     = 26;
  localparam int OPC_W       = 6;
  localparam int RD_LSB      = 21;
  localparam int RS1_LSB     = 16;
  localparam int RS2_LSB     = 11;
  localparam int REG_FIELD_W = 5;

  function automatic logic [REG_FIELD_W-1:0] rs1Field(input logic [31:0] instr);
    return instr[RS1_LSB +: REG_FIELD_W];
  endfunction

  function automatic logic [REG_FIELD_W-1:0] rs2Field(input logic [31:0] instr);
    return instr[RS2_LSB +: REG_FIELD_W];
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: issue reserves a destination, writeback releases it.
// A reservation beats a same-cycle release of the same register.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_WR   = 1,
  parameter bit ZERO_R0  = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
  input  logic                     rsv_en_i,
  input  logic [ADDR_W-1:0]        rsv_addr_i,
  output logic [NUM_REGS-1:0]      busy_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  // Release first, then reserve, so the new producer stays outstanding
  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en_i[w]) busy_d[wr_addr_i[w*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (rsv_en_i) busy_d[rsv_addr_i] = 1'b1;
    if (ZERO_R0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with registered reads and a busy scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter bit ZERO_R0  = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_RD-1:0]        rd_en_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
  input  logic                     rsv_en_i,
  input  logic [ADDR_W-1:0]        rsv_addr_i,
  output logic [NUM_REGS-1:0]      busy_o
);

  logic [DATA_W-1:0]        regs_q [NUM_REGS];
  logic [NUM_RD*DATA_W-1:0] rdData_q, rdData_d;
  logic [NUM_RD-1:0]        rdBusy;
  logic [NUM_REGS-1:0]      busyVec;
  logic [ADDR_W-1:0]        rdAddr [NUM_RD];

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .NUM_WR   (NUM_WR),
    .ZERO_R0  (ZERO_R0)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .rsv_en_i   (rsv_en_i),
    .rsv_addr_i (rsv_addr_i),
    .busy_o     (busyVec)
  );

  // Ascending port loop: the highest-indexed writer to an address wins
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en_i[w] && !(ZERO_R0 && wr_addr_i[w*ADDR_W +: ADDR_W] == '0))
          regs_q[wr_addr_i[w*ADDR_W +: ADDR_W]] <= wr_data_i[w*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_RD; p++) rdAddr[p] = rd_addr_i[p*ADDR_W +: ADDR_W];
  end

  always_comb begin
    rdData_d = rdData_q;
    rdBusy   = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rdBusy[p] = busyVec[rdAddr[p]];
      if (rd_en_i[p]) rdData_d[p*DATA_W +: DATA_W] = regs_q[rdAddr[p]];
`ifdef REGFILE_BYPASS_EN
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en_i[w] && wr_addr_i[w*ADDR_W +: ADDR_W] == rdAddr[p]) begin
          rdBusy[p] = 1'b0;
          if (rd_en_i[p]) rdData_d[p*DATA_W +: DATA_W] = wr_data_i[w*DATA_W +: DATA_W];
        end
      end
`endif
      if (ZERO_R0 && rd_en_i[p] && rdAddr[p] == '0) rdData_d[p*DATA_W +: DATA_W] = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rdData_q <= '0;
    else       rdData_q <= rdData_d;
  end

  assign rd_data_o = rdData_q;
  assign rd_busy_o = rdBusy;
  assign busy_o    = busyVec;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (2 read, 2 write ports, ZERO_R0 on); read
// results are queued when a read is driven and compared after the edge.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  rd_en_i;
  logic [9:0]  rd_addr_i;
  logic [63:0] rd_data_o;
  logic [1:0]  rd_busy_o;
  logic [1:0]  wr_en_i;
  logic [9:0]  wr_addr_i;
  logic [63:0] wr_data_i;
  logic        rsv_en_i;
  logic [4:0]  rsv_addr_i;
  logic [31:0] busy_o;

  typedef struct {
    string       tag;
    int          port;
    logic [31:0] data;
  } expT;

  expT expQ[$];
  int  checks = 0;
  int  errors = 0;

  regfile_mp #(
    .DATA_W   (32),
    .NUM_REGS (32),
    .NUM_RD   (2),
    .NUM_WR   (2),
    .ZERO_R0  (1'b1)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_en_i    (rd_en_i),
    .rd_addr_i  (rd_addr_i),
    .rd_data_o  (rd_data_o),
    .rd_busy_o  (rd_busy_o),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .wr_data_i  (wr_data_i),
    .rsv_en_i   (rsv_en_i),
    .rsv_addr_i (rsv_addr_i),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      $error("[TB] %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic clearInputs;
    rd_en_i  = '0;
    wr_en_i  = '0;
    rsv_en_i = 1'b0;
  endtask

  task automatic driveRead(input int port, input logic [4:0] addr,
                           input logic [31:0] expected, input string tag);
    rd_en_i[port]          = 1'b1;
    rd_addr_i[port*5 +: 5] = addr;
    expQ.push_back('{tag, port, expected});
  endtask

  task automatic expectHold(input int port, input logic [31:0] expected,
                            input string tag);
    rd_en_i[port] = 1'b0;
    expQ.push_back('{tag, port, expected});
  endtask

  task automatic driveWrite(input int port, input logic [4:0] addr,
                            input logic [31:0] data);
    wr_en_i[port]            = 1'b1;
    wr_addr_i[port*5 +: 5]   = addr;
    wr_data_i[port*32 +: 32] = data;
  endtask

  task automatic driveReserve(input logic [4:0] addr);
    rsv_en_i   = 1'b1;
    rsv_addr_i = addr;
  endtask

  // One clock edge, then compare every read result queued for it
  task automatic applyStimulus;
    expT e;
    @(posedge clk_i);
    #1;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput(e.tag, rd_data_o[e.port*32 +: 32], e.data);
    end
    clearInputs();
  endtask

  initial begin
    rst_i      = 1'b1;
    rd_addr_i  = '0;
    wr_addr_i  = '0;
    wr_data_i  = '0;
    rsv_addr_i = '0;
    clearInputs();
    applyStimulus();
    applyStimulus();
    rst_i = 1'b0;
    checkOutput("reset_busy", busy_o, 32'h0);
    checkOutput("reset_rd_p0", rd_data_o[31:0], 32'h0);
    checkOutput("reset_rd_p1", rd_data_o[63:32], 32'h0);

    for (int r = 0; r < 32; r++) begin
      driveRead(0, 5'(r), 32'h0, "init_read_p0");
      driveRead(1, 5'(31 - r), 32'h0, "init_read_p1");
      applyStimulus();
    end
    checkOutput("init_busy", busy_o, 32'h0);

    driveWrite(0, 5'd5, 32'hDEADBEEF);
    applyStimulus();
    driveRead(0, 5'd5, 32'hDEADBEEF, "r5_read");
    applyStimulus();
    rd_addr_i[4:0] = 5'd7;
    expectHold(0, 32'hDEADBEEF, "r5_hold");
    applyStimulus();

    driveWrite(0, 5'd7, 32'h11);
    driveWrite(1, 5'd7, 32'h22);
    applyStimulus();
    driveRead(1, 5'd7, 32'h22, "r7_dual_write");
    applyStimulus();

    driveWrite(0, 5'd0, 32'hFFFFFFFF);
    driveReserve(5'd0);
    applyStimulus();
    checkOutput("r0_busy", {31'h0, busy_o[0]}, 32'h0);
    driveRead(0, 5'd0, 32'h0, "r0_read");
    applyStimulus();

    driveReserve(5'd9);
    applyStimulus();
    rd_addr_i[4:0] = 5'd9;
    #1;
    checkOutput("r9_rd_busy_set", {31'h0, rd_busy_o[0]}, 32'h1);
    checkOutput("r9_busy_vec", busy_o, 32'h0000_0200);
    driveWrite(0, 5'd9, 32'h99);
    driveReserve(5'd9);
    #1;
    checkOutput("r9_rd_busy_wr_mask", {31'h0, rd_busy_o[0]}, BYPASS ? 32'h0 : 32'h1);
    applyStimulus();
    checkOutput("r9_rsv_wins", {31'h0, busy_o[9]}, 32'h1);
    driveWrite(1, 5'd9, 32'h9A);
    applyStimulus();
    checkOutput("r9_release", {31'h0, busy_o[9]}, 32'h0);
    checkOutput("r9_rd_busy_clear", {31'h0, rd_busy_o[0]}, 32'h0);

    driveReserve(5'd4);
    applyStimulus();
    driveReserve(5'd4);
    driveWrite(0, 5'd11, 32'hB);
    applyStimulus();
    checkOutput("r4_double_rsv", busy_o, 32'h0000_0010);
    driveWrite(0, 5'd4, 32'h44);
    applyStimulus();
    checkOutput("r4_single_release", busy_o, 32'h0);

    driveWrite(0, 5'd3, 32'hAA);
    applyStimulus();
    driveWrite(0, 5'd3, 32'h1234);
    driveRead(1, 5'd3, BYPASS ? 32'h1234 : 32'hAA, "r3_same_cycle");
    applyStimulus();
    driveRead(1, 5'd3, 32'h1234, "r3_after");
    applyStimulus();
    driveWrite(0, 5'd3, 32'h1);
    driveWrite(1, 5'd3, 32'h2);
    driveRead(0, 5'd3, BYPASS ? 32'h2 : 32'h1234, "r3_dual_same_cycle");
    applyStimulus();
    driveRead(0, 5'd3, 32'h2, "r3_dual_after");
    applyStimulus();
    driveWrite(1, 5'd0, 32'h5);
    driveRead(0, 5'd0, 32'h0, "r0_same_cycle");
    applyStimulus();

    driveWrite(0, 5'd12, 32'h55);
    driveReserve(5'd13);
    rst_i = 1'b1;
    applyStimulus();
    rst_i = 1'b0;
    checkOutput("rst_busy", busy_o, 32'h0);
    checkOutput("rst_rd_p0", rd_data_o[31:0], 32'h0);
    checkOutput("rst_rd_p1", rd_data_o[63:32], 32'h0);
    driveRead(0, 5'd12, 32'h0, "r12_after_rst");
    driveRead(1, 5'd5, 32'h0, "r5_after_rst");
    applyStimulus();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file with an integrated busy scoreboard, serving the CPU decode/issue stage (read side) and writeback stage (write side). Provides NUM_RD registered read ports, NUM_WR write ports with fixed priority, and per-register busy bits that issue reserves and writeback releases, so decode can stall on RAW hazards. Replaces the fixed 32×32, two-read, one-write register file.

## Interface
- DATA_W, 32, register width in bits
- NUM_REGS, 32, register count (power of two, ≥2); ADDR_W = $clog2(NUM_REGS) derived
- NUM_RD, 2, read ports (1..4)
- NUM_WR, 1, write ports (1..2)
- ZERO_R0, 1, 1 = register 0 reads zero, ignores writes, never busy
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous active-high reset
- rd_en_i  in  NUM_RD  per-port read enable
- rd_addr_i  in  NUM_RD*ADDR_W  read addresses, port p at [p*ADDR_W +: ADDR_W]
- rd_data_o  out  NUM_RD*DATA_W  registered read data
- rd_busy_o  out  NUM_RD  combinational busy bit of addressed register
- wr_en_i  in  NUM_WR  per-port write enable
- wr_addr_i  in  NUM_WR*ADDR_W  write addresses
- wr_data_i  in  NUM_WR*DATA_W  write data
- rsv_en_i  in  1  reserve destination (issue)
- rsv_addr_i  in  ADDR_W  register to mark busy
- busy_o  out  NUM_REGS  full scoreboard vector

## Operation
- Reset: all registers 0, all busy bits 0, rd_data_o 0.
- Write: on rising edge with wr_en_i[w], reg[wr_addr_i[w]] ← wr_data_i[w]. Two ports same address same cycle: higher port index wins.
- Write also clears busy[wr_addr] unless rsv_en_i targets the same address that cycle (reservation wins; new producer outstanding).
- Reserve: rsv_en_i sets busy[rsv_addr_i]; reserving an already-busy register keeps it busy (single bit, no count).
- Read: with rd_en_i[p], rd_data_o[p] ← reg[rd_addr_i[p]] at the edge; without rd_en_i[p], rd_data_o[p] holds.
- rd_busy_o[p] = busy[rd_addr_i[p]], independent of rd_en_i, not including same-cycle release.
- ZERO_R0=1: address 0 always returns 0, writes dropped, reserve ignored, busy[0] constant 0.
- rst_i during a write or reserve: reset wins, write and reserve discarded.

## Timing
- Read latency 1 cycle: address at edge N, data valid after edge N, held until next enabled read.
- Write visible to a read issued the cycle after the write edge.
- Same-cycle read/write same address: per Configuration.
- busy set/clear take effect after the edge; rd_busy_o reflects them from the next cycle.
- No backpressure; every enabled access completes in one cycle.

## Configuration
- REGFILE_BYPASS_EN defined: same-cycle write-to-read forwarding; rd_data_o[p] captures the winning wr_data_i for a matching enabled write (ZERO_R0 still forces 0 at address 0), and rd_busy_o[p] is masked to 0 when a matching write is present.
- Not defined: read captures pre-write register contents; rd_busy_o unmasked.

## Structure
- Package regfile_pkg: default DATA_W/NUM_REGS constants, opcode field constants (ALU_LW … ALU_MULI) and instruction field positions for operand decode by the instantiating stage.
- Sub-module regfile_scoreboard: busy vector, reserve/release priority, ZERO_R0 masking; the top keeps storage, write priority and read/bypass muxing.

## Test plan
- Reset then read all 32 registers on both ports -> every rd_data_o 0, busy_o 0.
- Write r5=0xDEADBEEF, next cycle read r5 on port 0 -> 0xDEADBEEF after one edge.
- NUM_WR=2, both ports write r7 (0x11, 0x22) same cycle -> subsequent read returns 0x22.
- Write r0=0xFFFFFFFF with ZERO_R0=1 -> r0 reads 0; rsv r0 -> busy_o[0] stays 0.
- Reserve r9, rd_busy_o=1 next cycle; write r9 while reserving r9 same cycle -> busy stays 1; lone write -> busy clears.
- Read r3 while writing r3=0x1234 (r3 held 0xAA) -> 0x1234 with REGFILE_BYPASS_EN, 0xAA without.
